// File: rtl/timer_pkg.sv
// Shared definitions for the phase-timer bank: channel state encoding,
// default dimensions and the seconds-tick divider constant.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  localparam int DEFAULT_N_CH  = 4;
  localparam int DEFAULT_W     = 6;
  localparam int TICKS_PER_SEC = 50_000_000;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: loads a duration, decrements on each enabled tick,
// and emits a registered one-cycle expiry pulse with optional auto-reload.
module timer_channel
  import timer_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         syncReset_i,
  input  logic         tick_i,
  input  logic         hold_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         reloadEn_i,
  input  logic [W-1:0] value_i,
  output logic         busy_o,
  output logic         expired_o,
  output logic [W-1:0] remaining_o
);

  chan_state_e  state_q, state_d;
  logic [W-1:0] remaining_q, remaining_d;
  logic [W-1:0] period_q, period_d;
  logic         reload_q, reload_d;
  logic         expired_q, expired_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      period_q    <= '0;
      reload_q    <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      period_q    <= period_d;
      reload_q    <= reload_d;
      expired_q   <= expired_d;
    end
  end

  // Priority: sync clear, abort, start, tick. Expiry is a pulse, so it
  // defaults low every cycle and is only raised by the branch that expires.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    period_d    = period_q;
    reload_d    = reload_q;
    expired_d   = 1'b0;

    if (syncReset_i) begin
      state_d     = IDLE;
      remaining_d = '0;
      period_d    = '0;
      reload_d    = 1'b0;
    end else if (abort_i) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (start_i) begin
      if (value_i != '0) begin
        state_d     = RUN;
        remaining_d = value_i;
        period_d    = value_i;
        reload_d    = reloadEn_i;
      end else begin
        state_d     = IDLE;
        remaining_d = '0;
        expired_d   = 1'b1;
      end
    end else if (tick_i && !hold_i && (state_q == RUN)) begin
      if (remaining_q > W'(1)) begin
        remaining_d = remaining_q - W'(1);
      end else begin
        expired_d = 1'b1;
        if (reload_q) begin
          remaining_d = period_q;
        end else begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      end
    end
  end

  assign busy_o      = (state_q == RUN);
  assign expired_o   = expired_q;
  assign remaining_o = remaining_q;

endmodule

// File: rtl/multi_channel_timer.sv
// Bank of independent countdown timers sharing one seconds tick; each channel
// slices its duration and remaining count out of the packed buses.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int N_CH = DEFAULT_N_CH,
  parameter int W    = DEFAULT_W
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Sync_Reset,
  input  logic              Tick,
  input  logic              Hold,
  input  logic [N_CH-1:0]   Start,
  input  logic [N_CH-1:0]   Abort,
  input  logic [N_CH-1:0]   Reload_En,
  input  logic [N_CH*W-1:0] Value,
  output logic [N_CH-1:0]   Busy,
  output logic [N_CH-1:0]   Expired,
  output logic              Any_Expired,
  output logic [N_CH*W-1:0] Remaining
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    timer_channel #(
      .W(W)
    ) u_chan (
      .clk_i       (clk),
      .rst_i       (Reset),
      .syncReset_i (Sync_Reset),
      .tick_i      (Tick),
      .hold_i      (Hold),
      .start_i     (Start[i]),
      .abort_i     (Abort[i]),
      .reloadEn_i  (Reload_En[i]),
      .value_i     (Value[i*W +: W]),
      .busy_o      (Busy[i]),
      .expired_o   (Expired[i]),
      .remaining_o (Remaining[i*W +: W])
    );
  end

  assign Any_Expired = |Expired;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer: a per-cycle vector table followed
// by hand-written sequences for slow ticks, async reset and sync reset.
module tb_multi_channel_timer;

  localparam int N_CH = 4;
  localparam int W    = 6;

  typedef struct {
    logic [N_CH-1:0]   start;
    logic [N_CH-1:0]   abort;
    logic [N_CH-1:0]   reloadEn;
    logic [N_CH*W-1:0] value;
    logic              tick;
    logic              hold;
    logic              syncRst;
    logic [N_CH-1:0]   expBusy;
    logic [N_CH-1:0]   expExpired;
    logic [N_CH*W-1:0] expRem;
  } vec_t;

  logic              clk = 1'b0;
  logic              Reset;
  logic              Sync_Reset;
  logic              Tick;
  logic              Hold;
  logic [N_CH-1:0]   Start;
  logic [N_CH-1:0]   Abort;
  logic [N_CH-1:0]   Reload_En;
  logic [N_CH*W-1:0] Value;
  logic [N_CH-1:0]   Busy;
  logic [N_CH-1:0]   Expired;
  logic              Any_Expired;
  logic [N_CH*W-1:0] Remaining;

  int compared   = 0;
  int mismatched = 0;

  vec_t vecs[39];

  multi_channel_timer #(
    .N_CH(N_CH),
    .W   (W)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Sync_Reset (Sync_Reset),
    .Tick       (Tick),
    .Hold       (Hold),
    .Start      (Start),
    .Abort      (Abort),
    .Reload_En  (Reload_En),
    .Value      (Value),
    .Busy       (Busy),
    .Expired    (Expired),
    .Any_Expired(Any_Expired),
    .Remaining  (Remaining)
  );

  always #5 clk = ~clk;

  function automatic logic [N_CH*W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  function automatic vec_t mk(input logic [3:0] st, input logic [3:0] ab, input logic [3:0] rl,
                              input int v0, input int v1, input int v2, input int v3,
                              input logic tk, input logic hd, input logic sr,
                              input logic [3:0] eb, input logic [3:0] ee,
                              input int r0, input int r1, input int r2, input int r3);
    vec_t v;
    v.start = st; v.abort = ab; v.reloadEn = rl;
    v.value = pack4(v0, v1, v2, v3);
    v.tick = tk; v.hold = hd; v.syncRst = sr;
    v.expBusy = eb; v.expExpired = ee;
    v.expRem = pack4(r0, r1, r2, r3);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [N_CH-1:0] eb,
                             input logic [N_CH-1:0] ee, input logic [N_CH*W-1:0] er);
    compared++;
    if (Busy !== eb) begin
      mismatched++;
      $display("[TB] FAIL %s busy: got %b expected %b", name, Busy, eb);
    end
    compared++;
    if (Expired !== ee) begin
      mismatched++;
      $display("[TB] FAIL %s expired: got %b expected %b", name, Expired, ee);
    end
    compared++;
    if (Any_Expired !== (|ee)) begin
      mismatched++;
      $display("[TB] FAIL %s any_expired: got %b expected %b", name, Any_Expired, |ee);
    end
    compared++;
    if (Remaining !== er) begin
      mismatched++;
      $display("[TB] FAIL %s remaining: got %h expected %h", name, Remaining, er);
    end
  endtask

  task automatic driveVec(input vec_t v);
    Start      = v.start;
    Abort      = v.abort;
    Reload_En  = v.reloadEn;
    Value      = v.value;
    Tick       = v.tick;
    Hold       = v.hold;
    Sync_Reset = v.syncRst;
  endtask

  // One clock per vector: drive on the falling edge, check just after the rising edge.
  task automatic applyStimulus(input string name, input vec_t v);
    @(negedge clk);
    driveVec(v);
    @(posedge clk);
    #1;
    checkOutput(name, v.expBusy, v.expExpired, v.expRem);
  endtask

  initial begin
    vec_t q;
    // Reload channel: pulses on ticks 2, 4, 6 and reloads to 2 each time.
    vecs[0]  = mk(4'b0010, 4'b0000, 4'b0010, 0,2,0,0, 0,0,0, 4'b0010, 4'b0000, 0,2,0,0);
    vecs[1]  = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0010, 4'b0000, 0,1,0,0);
    vecs[2]  = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0010, 4'b0010, 0,2,0,0);
    vecs[3]  = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 0,0,0, 4'b0010, 4'b0000, 0,2,0,0);
    vecs[4]  = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0010, 4'b0000, 0,1,0,0);
    vecs[5]  = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0010, 4'b0010, 0,2,0,0);
    vecs[6]  = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0010, 4'b0000, 0,1,0,0);
    vecs[7]  = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0010, 4'b0010, 0,2,0,0);
    vecs[8]  = mk(4'b0000, 4'b0010, 4'b0000, 0,0,0,0, 0,0,0, 4'b0000, 4'b0000, 0,0,0,0);
    // Abort after two ticks, then start+abort together.
    vecs[9]  = mk(4'b0100, 4'b0000, 4'b0000, 0,0,5,0, 0,0,0, 4'b0100, 4'b0000, 0,0,5,0);
    vecs[10] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0100, 4'b0000, 0,0,4,0);
    vecs[11] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0100, 4'b0000, 0,0,3,0);
    vecs[12] = mk(4'b0000, 4'b0100, 4'b0000, 0,0,0,0, 0,0,0, 4'b0000, 4'b0000, 0,0,0,0);
    vecs[13] = mk(4'b0100, 4'b0100, 4'b0000, 0,0,7,0, 0,0,0, 4'b0000, 4'b0000, 0,0,0,0);
    // Zero-length start, start coincident with tick, restart without expiry.
    vecs[14] = mk(4'b1000, 4'b0000, 4'b0000, 0,0,0,0, 0,0,0, 4'b0000, 4'b1000, 0,0,0,0);
    vecs[15] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 0,0,0, 4'b0000, 4'b0000, 0,0,0,0);
    vecs[16] = mk(4'b1000, 4'b0000, 4'b0000, 0,0,0,9, 1,0,0, 4'b1000, 4'b0000, 0,0,0,9);
    vecs[17] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b1000, 4'b0000, 0,0,0,8);
    vecs[18] = mk(4'b1000, 4'b0000, 4'b0000, 0,0,0,5, 0,0,0, 4'b1000, 4'b0000, 0,0,0,5);
    vecs[19] = mk(4'b0000, 4'b1000, 4'b0000, 0,0,0,0, 0,0,0, 4'b0000, 4'b0000, 0,0,0,0);
    // Hold freezes counts but start is still honoured.
    vecs[20] = mk(4'b0001, 4'b0000, 4'b0000, 4,0,0,0, 0,0,0, 4'b0001, 4'b0000, 4,0,0,0);
    vecs[21] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,1,0, 4'b0001, 4'b0000, 4,0,0,0);
    vecs[22] = mk(4'b0100, 4'b0000, 4'b0000, 0,0,2,0, 1,1,0, 4'b0101, 4'b0000, 4,0,2,0);
    vecs[23] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,1,0, 4'b0101, 4'b0000, 4,0,2,0);
    vecs[24] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0101, 4'b0000, 3,0,1,0);
    vecs[25] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0001, 4'b0100, 2,0,0,0);
    vecs[26] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0001, 4'b0000, 1,0,0,0);
    vecs[27] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0000, 4'b0001, 0,0,0,0);
    vecs[28] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 0,0,0, 4'b0000, 4'b0000, 0,0,0,0);
    // Pulse drops on the next edge even when a start lands on that cycle.
    vecs[29] = mk(4'b0001, 4'b0000, 4'b0000, 1,0,0,0, 0,0,0, 4'b0001, 4'b0000, 1,0,0,0);
    vecs[30] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0000, 4'b0001, 0,0,0,0);
    vecs[31] = mk(4'b0001, 4'b0000, 4'b0000, 2,0,0,0, 0,0,0, 4'b0001, 4'b0000, 2,0,0,0);
    // Simultaneous expiry on two channels.
    vecs[32] = mk(4'b0110, 4'b0000, 4'b0000, 0,1,1,0, 0,0,0, 4'b0111, 4'b0000, 2,1,1,0);
    vecs[33] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0001, 4'b0110, 1,0,0,0);
    vecs[34] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0000, 4'b0001, 0,0,0,0);
    // Sync reset beats a tick that would have expired ch1 and a start on ch2.
    vecs[35] = mk(4'b0011, 4'b0000, 4'b0010, 10,2,0,0, 0,0,0, 4'b0011, 4'b0000, 10,2,0,0);
    vecs[36] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0011, 4'b0000, 9,1,0,0);
    vecs[37] = mk(4'b0100, 4'b0000, 4'b0000, 0,0,3,0, 1,0,1, 4'b0000, 4'b0000, 0,0,0,0);
    vecs[38] = mk(4'b0000, 4'b0000, 4'b0000, 0,0,0,0, 1,0,0, 4'b0000, 4'b0000, 0,0,0,0);

    Reset = 1'b1;
    driveVec(mk(0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0,0,0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 4'b0000, 4'b0000, '0);
    @(negedge clk);
    Reset = 1'b0;

    for (int i = 0; i < 39; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Ch0 counts 3 with a tick only every tenth cycle.
    applyStimulus("slow_start", mk(4'b0001,0,0, 3,0,0,0, 0,0,0, 4'b0001,4'b0000, 3,0,0,0));
    for (int t = 1; t <= 3; t++) begin
      for (int c = 0; c < 9; c++) begin
        q = mk(0,0,0, 0,0,0,0, 0,0,0, 4'b0001, 4'b0000, 4-t,0,0,0);
        @(negedge clk);
        driveVec(q);
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("slow_gap%0d", t), 4'b0001, 4'b0000, pack4(4-t,0,0,0));
      applyStimulus($sformatf("slow_tick%0d", t),
                    mk(0,0,0, 0,0,0,0, 1,0,0, (t < 3) ? 4'b0001 : 4'b0000,
                       (t == 3) ? 4'b0001 : 4'b0000, 3-t,0,0,0));
    end
    applyStimulus("slow_after", mk(0,0,0, 0,0,0,0, 0,0,0, 4'b0000,4'b0000, 0,0,0,0));

    // Async reset mid-count clears outputs before any clock edge.
    applyStimulus("ar_start", mk(4'b1111,0,0, 5,6,7,8, 0,0,0, 4'b1111,4'b0000, 5,6,7,8));
    applyStimulus("ar_tick",  mk(0,0,0, 0,0,0,0, 1,0,0, 4'b1111,4'b0000, 4,5,6,7));
    @(negedge clk);
    driveVec(mk(0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0,0,0));
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("ar_immediate", 4'b0000, 4'b0000, '0);
    @(negedge clk);
    Reset = 1'b0;
    applyStimulus("ar_after", mk(0,0,0, 0,0,0,0, 1,0,0, 4'b0000,4'b0000, 0,0,0,0));

    // Sync reset only takes effect at the next edge.
    applyStimulus("sr_start", mk(4'b1111,0,4'b1111, 1,2,3,4, 0,0,0, 4'b1111,4'b0000, 1,2,3,4));
    @(negedge clk);
    driveVec(mk(0,0,0, 0,0,0,0, 1,0,1, 0,0, 0,0,0,0));
    #1;
    checkOutput("sr_before_edge", 4'b1111, 4'b0000, pack4(1,2,3,4));
    @(posedge clk);
    #1;
    checkOutput("sr_after_edge", 4'b0000, 4'b0000, '0);
    applyStimulus("sr_quiet", mk(0,0,0, 0,0,0,0, 1,0,0, 4'b0000,4'b0000, 0,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
